// File: rtl/dma_cpl_router.sv
// Completion-return router: records {chan, len} of every accepted DMA request and
// turns each in-order engine completion into a one-hot done pulse. Optional macro: DMA_CPL_STATS_EN.
module dma_cpl_router #(
    parameter int N_SPLIT_CHAN  = 4,
    parameter int N_OUTSTANDING = 16,
    parameter int LEN_BITS      = 28,
    localparam int CB = (N_SPLIT_CHAN > 1) ? $clog2(N_SPLIT_CHAN) : 1,
    localparam int OB = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       issue_valid,
    input  logic [CB-1:0]              issue_chan,
    input  logic [LEN_BITS-1:0]        issue_len,
    input  logic                       cpl_valid,
    output logic                       issue_stall,
    output logic [N_SPLIT_CHAN-1:0]    m_cpl_valid,
    output logic [LEN_BITS-1:0]        m_cpl_len,
    output logic [OB:0]                outstanding,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic [N_SPLIT_CHAN*32-1:0] cpl_count
);

    localparam logic [OB:0] FULL_CNT = (OB+1)'(N_OUTSTANDING);
    localparam logic [CB:0] CHAN_LIM = (CB+1)'(N_SPLIT_CHAN);

    logic [CB-1:0]       chan_mem [N_OUTSTANDING];
    logic [LEN_BITS-1:0] len_mem  [N_OUTSTANDING];

    logic [OB-1:0] wr_ptr;
    logic [OB-1:0] rd_ptr;
    logic [OB:0]   count;
    logic [OB:0]   count_nxt;

    logic full;
    logic empty;
    logic chan_ok;
    logic wr_ok;
    logic rd_ok;

    logic [CB-1:0]       rd_chan;
    logic [LEN_BITS-1:0] rd_len;

    // Decisions use the registered count only, so a same-cycle issue can never feed a completion.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign chan_ok = ({1'b0, issue_chan} < CHAN_LIM);
    assign wr_ok   = issue_valid && !full && chan_ok;
    assign rd_ok   = cpl_valid && !empty;

    assign rd_chan = chan_mem[rd_ptr];
    assign rd_len  = len_mem[rd_ptr];

    assign count_nxt = count + (OB+1)'(wr_ok) - (OB+1)'(rd_ok);

    always_ff @(posedge aclk) begin
        if (wr_ok) begin
            chan_mem[wr_ptr] <= issue_chan;
            len_mem[wr_ptr]  <= issue_len;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            issue_stall   <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + OB'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + OB'(1);
            end
            count       <= count_nxt;
            issue_stall <= (count_nxt == FULL_CNT);
            if (issue_valid && !wr_ok) begin
                err_overflow <= 1'b1;
            end
            if (cpl_valid && empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Length holds its last value between pulses; only meaningful while m_cpl_valid is set.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_cpl_valid <= '0;
            m_cpl_len   <= '0;
        end else begin
            for (int i = 0; i < N_SPLIT_CHAN; i++) begin
                m_cpl_valid[i] <= rd_ok && (rd_chan == CB'(i));
            end
            if (rd_ok) begin
                m_cpl_len <= rd_len;
            end
        end
    end

    assign outstanding = count;

`ifdef DMA_CPL_STATS_EN
    for (genvar g = 0; g < N_SPLIT_CHAN; g++) begin : g_stats
        logic [31:0] cnt;

        always_ff @(posedge aclk) begin
            if (areset) begin
                cnt <= '0;
            end else if (m_cpl_valid[g]) begin
                cnt <= cnt + 32'd1;
            end
        end

        assign cpl_count[32*g +: 32] = cnt;
    end
`else
    assign cpl_count = '0;
`endif

endmodule

// File: tb/tb_dma_cpl_router.sv
// Self-checking bench for dma_cpl_router: directed vector table, hand sequences for
// the multi-cycle corners, and a randomized run against a queue-based reference model.
module tb_dma_cpl_router;

    localparam int NS = 5;
    localparam int NO = 16;
    localparam int LB = 16;
    localparam int CB = 3;
    localparam int OB = 4;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 issue_valid;
    logic [CB-1:0]        issue_chan;
    logic [LB-1:0]        issue_len;
    logic                 cpl_valid;
    logic                 issue_stall;
    logic [NS-1:0]        m_cpl_valid;
    logic [LB-1:0]        m_cpl_len;
    logic [OB:0]          outstanding;
    logic                 err_overflow;
    logic                 err_underflow;
    logic [NS*32-1:0]     cpl_count;

    dma_cpl_router #(
        .N_SPLIT_CHAN (NS),
        .N_OUTSTANDING(NO),
        .LEN_BITS     (LB)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .issue_valid  (issue_valid),
        .issue_chan   (issue_chan),
        .issue_len    (issue_len),
        .cpl_valid    (cpl_valid),
        .issue_stall  (issue_stall),
        .m_cpl_valid  (m_cpl_valid),
        .m_cpl_len    (m_cpl_len),
        .outstanding  (outstanding),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow),
        .cpl_count    (cpl_count)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of issued requests, sticky flags, per-channel totals.
    typedef struct {
        int            chan;
        logic [LB-1:0] len;
    } ent_t;

    ent_t          q[$];
    logic [NS-1:0] m_v;
    logic [LB-1:0] m_len;
    logic          m_eo;
    logic          m_eu;
    int unsigned   m_stats[NS];

    typedef struct {
        bit            iv;
        int            ch;
        logic [LB-1:0] len;
        bit            cv;
        logic [NS-1:0] exp_v;
        logic [LB-1:0] exp_len;
        int            exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS*32-1:0] model_stats();
        logic [NS*32-1:0] r;
        r = '0;
`ifdef DMA_CPL_STATS_EN
        for (int i = 0; i < NS; i++) r[32*i +: 32] = m_stats[i];
`endif
        return r;
    endfunction

    // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge.
    task automatic step(input bit rst, input bit iv, input int ch, input logic [LB-1:0] ln, input bit cv);
        int   pre;
        ent_t e;
        areset      = rst;
        issue_valid = iv;
        issue_chan  = ch[CB-1:0];
        issue_len   = ln;
        cpl_valid   = cv;
        @(posedge aclk);
        if (rst) begin
            q.delete();
            m_v   = '0;
            m_len = '0;
            m_eo  = 1'b0;
            m_eu  = 1'b0;
            for (int i = 0; i < NS; i++) m_stats[i] = 0;
        end else begin
            for (int i = 0; i < NS; i++) if (m_v[i]) m_stats[i]++;
            pre = q.size();
            m_v = '0;
            if (cv) begin
                if (pre > 0) begin
                    e     = q.pop_front();
                    m_v   = NS'(1) << e.chan;
                    m_len = e.len;
                end else begin
                    m_eu = 1'b1;
                end
            end
            if (iv) begin
                if (pre < NO && ch < NS) begin
                    e.chan = ch;
                    e.len  = ln;
                    q.push_back(e);
                end else begin
                    m_eo = 1'b1;
                end
            end
        end
        #1;
        chk("m_cpl_valid", m_cpl_valid, m_v);
        if (m_v != '0) chk("m_cpl_len", m_cpl_len, m_len);
        chk("outstanding", outstanding, q.size());
        chk("issue_stall", issue_stall, q.size() == NO);
        chk("err_overflow", err_overflow, m_eo);
        chk("err_underflow", err_underflow, m_eu);
        chk("cpl_count", cpl_count, model_stats());
        areset      = 1'b0;
        issue_valid = 1'b0;
        cpl_valid   = 1'b0;
    endtask

    initial begin
        areset = 1'b1; issue_valid = 1'b0; issue_chan = '0; issue_len = '0; cpl_valid = 1'b0;
        m_v = '0; m_len = '0; m_eo = 1'b0; m_eu = 1'b0;
        for (int i = 0; i < NS; i++) m_stats[i] = 0;

        vecs[0] = '{1, 2, 16'd64,  0, 5'b00000, 16'd0,   1};
        vecs[1] = '{1, 0, 16'd128, 0, 5'b00000, 16'd0,   2};
        vecs[2] = '{0, 0, 16'd0,   1, 5'b00100, 16'd64,  1};
        vecs[3] = '{0, 0, 16'd0,   1, 5'b00001, 16'd128, 0};
        vecs[4] = '{0, 0, 16'd0,   0, 5'b00000, 16'd0,   0};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_valid", m_cpl_valid, 5'b0);
        chk("rst_len", m_cpl_len, 16'd0);
        chk("rst_out", outstanding, 5'd0);
        chk("rst_stall", issue_stall, 1'b0);

        // Basic routing from the constant table
        for (int i = 0; i < 5; i++) begin
            step(0, vecs[i].iv, vecs[i].ch, vecs[i].len, vecs[i].cv);
            chk("tbl_valid", m_cpl_valid, vecs[i].exp_v);
            if (vecs[i].exp_v != '0) chk("tbl_len", m_cpl_len, vecs[i].exp_len);
            chk("tbl_out", outstanding, 5'(vecs[i].exp_out));
        end

        // Fill to full, overflow, then one completion releases stall
        for (int i = 0; i < NO; i++) step(0, 1, i % NS, LB'(100 + i), 0);
        chk("full_stall", issue_stall, 1'b1);
        chk("full_out", outstanding, 5'd16);
        chk("full_no_ovf", err_overflow, 1'b0);
        step(0, 1, 1, 16'hBEEF, 0);
        chk("ovf_flag", err_overflow, 1'b1);
        chk("ovf_out", outstanding, 5'd16);
        step(0, 0, 0, 0, 1);
        chk("unstall", issue_stall, 1'b0);
        chk("unstall_pulse", m_cpl_valid, 5'b00001);
        chk("unstall_len", m_cpl_len, 16'd100);
        for (int i = 0; i < NO - 1; i++) step(0, 0, 0, 0, 1);
        chk("drained", outstanding, 5'd0);

        // Out-of-range channel is dropped
        step(1, 0, 0, 0, 0);
        step(0, 1, 6, 16'd7, 0);
        chk("badchan_ovf", err_overflow, 1'b1);
        chk("badchan_out", outstanding, 5'd0);

        // Completion on empty with a simultaneous issue
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 16'd9, 1);
        chk("uf_flag", err_underflow, 1'b1);
        chk("uf_nopulse", m_cpl_valid, 5'b0);
        chk("uf_out", outstanding, 5'd1);
        step(0, 0, 0, 0, 1);
        chk("uf_next_pulse", m_cpl_valid, 5'b01000);
        chk("uf_next_len", m_cpl_len, 16'd9);

        // Continuous issue+completion, pointers wrap many times
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, i % NS, LB'(i), 0);
        for (int i = 3; i < 43; i++) begin
            step(0, 1, i % NS, LB'(i), 1);
            chk("steady_out", outstanding, 5'd3);
            chk("steady_pulse", m_cpl_valid, NS'(1) << ((i - 3) % NS));
            chk("steady_len", m_cpl_len, LB'(i - 3));
        end

        // Reset with requests outstanding
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 4, LB'(i + 1), 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("mrst_valid", m_cpl_valid, 5'b0);
        chk("mrst_len", m_cpl_len, 16'd0);
        chk("mrst_out", outstanding, 5'd0);
        chk("mrst_stall", issue_stall, 1'b0);
        chk("mrst_eo", err_overflow, 1'b0);
        chk("mrst_eu", err_underflow, 1'b0);
        chk("mrst_cnt", cpl_count, 160'd0);
        step(0, 0, 0, 0, 1);
        chk("mrst_uf", err_underflow, 1'b1);
        chk("mrst_nopulse", m_cpl_valid, 5'b0);

        // Per-channel statistics
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'd5, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
`ifdef DMA_CPL_STATS_EN
        chk("stats_ch1", cpl_count[63:32], 32'd3);
        chk("stats_ch0", cpl_count[31:0], 32'd0);
        chk("stats_hi", cpl_count[159:64], 96'd0);
`else
        chk("stats_off", cpl_count, 160'd0);
`endif

        // Randomized run against the model
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int pi;
            int pc;
            int ch;
            pi = (i < 1500) ? 70 : 40;
            pc = (i < 1500) ? 40 : 70;
            ch = ($urandom_range(0, 49) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, NS - 1));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pi, ch,
                 LB'($urandom), $urandom_range(0, 99) < pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
